// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the repeated-addition multiplier control path.
package mul_ctrl_pkg;

    // Operand / counter width; must match the counter's din/dout.
    localparam int MUL_WIDTH = 16;

    // Controller states. The encoding is fixed so that other blocks can decode it.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mul_ctrl.sv
// Control FSM for the repeated-addition multiplier: captures A, then B, from the
// shared data bus, then adds A into the product once per count until the counter is zero.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_din_vld,
    input  logic [WIDTH-1:0] i_cnt,
    output logic             o_lda,
    output logic             o_ldb,
    output logic             o_clrp,
    output logic             o_ldp,
    output logic             o_decb,
    output logic             o_busy,
    output logic             o_done
);

    state_t r_state;
    state_t w_next;
    logic   w_zero;

    // Full-width zero detect on the live counter value; the counter moves on the
    // same edge as the strobes, so this is re-evaluated every RUN cycle.
    assign w_zero = (i_cnt == '0);
    assign o_busy = (r_state != IDLE);

    // State register; reset abandons any multiply in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state and strobe decode; RUN strobes are Mealy on the counter value.
    always_comb begin
        w_next = r_state;
        o_lda  = 1'b0;
        o_ldb  = 1'b0;
        o_clrp = 1'b0;
        o_ldp  = 1'b0;
        o_decb = 1'b0;
        o_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_next = GET_A;
            end
            GET_A: begin
                if (i_din_vld) begin
                    o_lda  = 1'b1;
                    w_next = GET_B;
                end
            end
            GET_B: begin
                // Clearing the product while B loads keeps B=0 giving a zero product.
                if (i_din_vld) begin
                    o_ldb  = 1'b1;
                    o_clrp = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                if (!w_zero) begin
                    o_ldp  = 1'b1;
                    o_decb = 1'b1;
                end else begin
                    w_next = DONE;
                end
            end
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural counter, A register and accumulator.
module tb_mul_ctrl;
    import mul_ctrl_pkg::*;

    localparam int W = MUL_WIDTH;

    // Strobe vector order: {lda, ldb, clrp, ldp, decb, busy, done}
    localparam logic [6:0] S_ZERO = 7'b0000000;
    localparam logic [6:0] S_GA   = 7'b1000010;
    localparam logic [6:0] S_GB   = 7'b0110010;
    localparam logic [6:0] S_ADD  = 7'b0001110;
    localparam logic [6:0] S_BUSY = 7'b0000010;
    localparam logic [6:0] S_DONE = 7'b0000011;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         din_vld = 1'b0;
    logic [W-1:0] data = '0;
    logic [W-1:0] cnt;
    logic         lda, ldb, clrp, ldp, decb, busy, done;

    logic [W-1:0] areg;
    logic [31:0]  prod;

    int total = 0;
    int fails = 0;
    int ncyc;

    mul_ctrl #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_din_vld(din_vld), .i_cnt(cnt),
        .o_lda(lda), .o_ldb(ldb), .o_clrp(clrp), .o_ldp(ldp), .o_decb(decb),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    // Datapath models: down-counter, A register, product accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            areg <= '0;
            prod <= '0;
        end else begin
            if (ldb)       cnt <= data;
            else if (decb) cnt <= cnt - 1'b1;
            if (lda)       areg <= data;
            if (clrp)      prod <= '0;
            else if (ldp)  prod <= prod + 32'(areg);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, lda, ldb, clrp, ldp, decb, busy, done}, {25'd0, exp});
    endtask

    // One clock cycle: drive just after the rising edge, sample at the falling edge.
    task automatic drive(input logic s, input logic v, input logic [W-1:0] d);
        @(posedge clk);
        #1;
        start   = s;
        din_vld = v;
        data    = d;
        @(negedge clk);
        ncyc++;
    endtask

    // Full multiply; done cycle index is counted from the start cycle (cycle 0).
    task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b, input int ga,
                        input int gb, input logic spam, input int exp_done,
                        input logic [31:0] exp_prod);
        ncyc = -1;
        drive(1'b1, 1'b0, '0);
        chk_s("idle_start", S_ZERO);
        for (int i = 0; i < ga; i++) begin
            drive(spam, 1'b0, a);
            chk_s("gap_a", S_BUSY);
        end
        drive(spam, 1'b1, a);
        chk_s("get_a", S_GA);
        for (int i = 0; i < gb; i++) begin
            drive(spam, 1'b0, b);
            chk_s("gap_b", S_BUSY);
        end
        drive(spam, 1'b1, b);
        chk_s("get_b", S_GB);
        for (int i = 0; i < int'(b); i++) begin
            drive(spam, 1'b0, '0);
            chk_s("run_add", S_ADD);
        end
        drive(spam, 1'b0, '0);
        chk_s("run_zero", S_BUSY);
        drive(spam, 1'b0, '0);
        chk_s("done", S_DONE);
        chk("done_cycle", 32'(ncyc), 32'(exp_done));
        chk("product", prod, exp_prod);
    endtask

    initial begin
        // Reset state
        #2;
        chk_s("reset_outs", S_ZERO);
        chk("reset_state", 32'(dut.r_state), 32'(IDLE));
        @(posedge clk); #1; rst = 1'b0;
        drive(1'b0, 1'b1, 16'd9);
        chk_s("idle_no_start", S_ZERO);

        // 1: A=5, B=3
        mult(16'd5, 16'd3, 0, 0, 1'b0, 7, 32'd15);
        drive(1'b0, 1'b0, '0);
        chk_s("idle_after1", S_ZERO);

        // 2: A=7, B=0
        mult(16'd7, 16'd0, 0, 0, 1'b0, 4, 32'd0);
        drive(1'b0, 1'b0, '0);
        chk_s("idle_after2", S_ZERO);

        // 3: din_vld gaps, A=4, B=6
        mult(16'd4, 16'd6, 3, 2, 1'b0, 15, 32'd24);
        drive(1'b0, 1'b0, '0);
        chk_s("idle_after3", S_ZERO);

        // 4: start held while busy, A=2, B=9
        mult(16'd2, 16'd9, 1, 1, 1'b1, 15, 32'd18);
        drive(1'b0, 1'b0, '0);
        chk_s("idle_after4", S_ZERO);

        // 5: reset mid-RUN after 4 adds, A=3, B=10
        drive(1'b1, 1'b0, '0);
        drive(1'b0, 1'b1, 16'd3);
        drive(1'b0, 1'b1, 16'd10);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, '0);
        chk_s("run_before_rst", S_ADD);
        chk("cnt_before_rst", 32'(cnt), 32'd7);
        @(posedge clk); #1; rst = 1'b1; din_vld = 1'b1;
        #1;
        chk_s("rst_mid_run", S_ZERO);
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));
        @(posedge clk); #1; rst = 1'b0; din_vld = 1'b0;
        drive(1'b0, 1'b0, '0);
        chk_s("after_rst_idle", S_ZERO);
        mult(16'd3, 16'd2, 0, 0, 1'b0, 6, 32'd6);

        // 6: back-to-back start in the cycle right after done
        mult(16'hFFFF, 16'd1, 0, 0, 1'b0, 5, 32'd65535);
        drive(1'b0, 1'b0, '0);
        chk_s("idle_final", S_ZERO);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
